// File: rtl/months.sv
// Month-of-year counter: steps on done_day rising edges in run mode, edited by ticks in setup mode.
// Month updates one posedge after the sampled event; done_month pulses one cycle on the 12->1 run-mode wrap.
module months (
  input  logic       clk,
  input  logic       rst,
  input  logic       display,
  input  logic       setup_month,
  input  logic       inc_dec_month,
  input  logic       tick,
  input  logic       done_day,
  input  logic [6:0] curr_year,
  output logic [5:0] month,
  output logic [5:0] month_len,
  output logic       done_month
);

  logic       done_day_d;
  logic       tick_d;
  logic       day_evt;
  logic       tick_evt;
  logic [5:0] month_nxt;
  logic       done_month_nxt;
  logic       year_unused;

  assign day_evt     = done_day & ~done_day_d;
  assign tick_evt    = tick & ~tick_d;
  // Only the low two year bits decide leap years.
  assign year_unused = ^curr_year[6:2];

  always_comb begin
    month_nxt      = month;
    done_month_nxt = 1'b0;
    if (month == 6'd0 || month > 6'd12) begin
      month_nxt = 6'd1;
    end else if (!display) begin
      if (day_evt) begin
        if (month == 6'd12) begin
          month_nxt      = 6'd1;
          done_month_nxt = 1'b1;
        end else begin
          month_nxt = month + 6'd1;
        end
      end
    end else if (!setup_month && tick_evt) begin
      if (inc_dec_month)
        month_nxt = (month == 6'd12) ? 6'd1 : month + 6'd1;
      else
        month_nxt = (month == 6'd1) ? 6'd12 : month - 6'd1;
    end
  end

  // Edge-detect history updates every cycle so a level held across a mode change fires only once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      month      <= 6'd1;
      done_month <= 1'b0;
      done_day_d <= 1'b0;
      tick_d     <= 1'b0;
    end else begin
      month      <= month_nxt;
      done_month <= done_month_nxt;
      done_day_d <= done_day;
      tick_d     <= tick;
    end
  end

  always_comb begin
    month_len = 6'd30;
    case (month)
      6'd1, 6'd3, 6'd5, 6'd7, 6'd8, 6'd10, 6'd12: month_len = 6'd31;
      6'd2:    month_len = (curr_year[1:0] == 2'b00) ? 6'd29 : 6'd28;
      default: month_len = 6'd30;
    endcase
  end

endmodule

// File: tb/tb_months.sv
// Self-checking bench for months: directed tables, multi-cycle corner sequences, then random traffic vs a model.
module tb_months;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       display = 1'b0;
  logic       setup_month = 1'b1;
  logic       inc_dec_month = 1'b1;
  logic       tick = 1'b0;
  logic       done_day = 1'b0;
  logic [6:0] curr_year = 7'd23;
  logic [5:0] month;
  logic [5:0] month_len;
  logic       done_month;

  int n_chk = 0;
  int n_err = 0;

  months dut (
    .clk(clk), .rst(rst), .display(display), .setup_month(setup_month),
    .inc_dec_month(inc_dec_month), .tick(tick), .done_day(done_day),
    .curr_year(curr_year), .month(month), .month_len(month_len),
    .done_month(done_month)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic disp;
    logic setup;
    logic inc;
    logic tk;
    logic dd;
    int   exp_month;
    logic exp_done;
  } vec_t;

  typedef struct {
    int target;
    int year;
    int exp_len;
  } len_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Drive inputs on the falling edge, sample just after the following rising edge.
  task automatic step(input logic d, input logic s, input logic i, input logic t, input logic dd);
    @(negedge clk);
    display = d; setup_month = s; inc_dec_month = i; tick = t; done_day = dd;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; tick = 1'b0; done_day = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic set_month(input int target);
    for (int k = 0; k < 13 && month != target[5:0]; k++) begin
      step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
      step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    end
    chk("set_month", {26'd0, month}, target);
  endtask

  // Reference model written from the calendar rules.
  function automatic int model_len(input int m, input int yr);
    int days[12] = '{31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};
    if (m < 1 || m > 12) return 30;
    if (m == 2 && (yr % 4) == 0) return 29;
    return days[m-1];
  endfunction

  vec_t vecs[10];
  len_t lens[7];

  initial begin
    vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 12, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0,  1, 1'b0};
    vecs[2] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0,  2, 1'b0};
    vecs[3] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0,  1, 1'b0};
    vecs[4] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0,  1, 1'b0};
    vecs[5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1,  1, 1'b0};
    vecs[6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0,  1, 1'b0};
    vecs[7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1,  1, 1'b0};
    vecs[8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1,  2, 1'b0};
    vecs[9] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1,  3, 1'b0};

    lens[0] = '{2, 24, 29};
    lens[1] = '{2, 23, 28};
    lens[2] = '{4, 23, 30};
    lens[3] = '{12, 23, 31};
    lens[4] = '{2, 0, 29};
    lens[5] = '{11, 99, 30};
    lens[6] = '{1, 50, 31};

    // Asynchronous reset values.
    #2 rst = 1'b1;
    #1;
    chk("reset_month", {26'd0, month}, 1);
    chk("reset_done", {31'd0, done_month}, 0);
    chk("reset_len", {26'd0, month_len}, 31);
    @(negedge clk);
    rst = 1'b0;

    // Run mode: eleven single-cycle pulses, then the wrap.
    for (int k = 1; k <= 12; k++) begin
      step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
      chk("run_month", {26'd0, month}, (k % 12) + 1);
      chk("run_done", {31'd0, done_month}, (k == 12) ? 1 : 0);
      step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      chk("run_done_low", {31'd0, done_month}, 0);
    end

    // done_day held for five cycles at month 3 gives a single step.
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("pre_hold_month", {26'd0, month}, 3);
    for (int k = 0; k < 5; k++) begin
      step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
      chk("day_held_month", {26'd0, month}, 4);
    end
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);

    // Directed table of edit, hold and ignore rules from a fresh reset.
    do_reset();
    for (int v = 0; v < 10; v++) begin
      step(vecs[v].disp, vecs[v].setup, vecs[v].inc, vecs[v].tk, vecs[v].dd);
      chk($sformatf("vec%0d_month", v), {26'd0, month}, vecs[v].exp_month);
      chk($sformatf("vec%0d_done", v), {31'd0, done_month}, {31'd0, vecs[v].exp_done});
      step(vecs[v].disp, vecs[v].setup, vecs[v].inc, 1'b0, 1'b0);
      chk($sformatf("vec%0d_idle", v), {26'd0, month}, vecs[v].exp_month);
    end

    // Tick held four cycles in edit mode gives a single step (3 -> 4).
    for (int k = 0; k < 4; k++) begin
      step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
      chk("tick_held_month", {26'd0, month}, 4);
      chk("tick_held_done", {31'd0, done_month}, 0);
    end
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);

    // Month length table.
    for (int v = 0; v < 7; v++) begin
      set_month(lens[v].target);
      @(negedge clk);
      curr_year = lens[v].year[6:0];
      #1;
      chk($sformatf("len%0d", v), {26'd0, month_len}, lens[v].exp_len);
    end

    // Reset mid-run at month 7 with done_day high.
    set_month(7);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    done_day = 1'b1;
    #2 rst = 1'b1;
    #1;
    chk("midrst_month", {26'd0, month}, 1);
    chk("midrst_done", {31'd0, done_month}, 0);
    @(posedge clk);
    #1;
    chk("midrst_hold", {26'd0, month}, 1);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_step", {26'd0, month}, 2);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    chk("post_rst_once", {26'd0, month}, 2);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);

    // Recovery from an illegal month value, starting from month 1.
    do_reset();
    @(negedge clk);
    display = 1'b1; setup_month = 1'b1;
    force dut.month = 6'd13;
    #1;
    chk("illegal_len", {26'd0, month_len}, 30);
    release dut.month;
    @(posedge clk);
    #1;
    chk("recover_month", {26'd0, month}, 1);
    chk("recover_done", {31'd0, done_month}, 0);

    // Random traffic against the model.
    begin
      int   m;
      logic pd;
      logic pt;
      int   exp_done;
      logic d, s, i, t, dd, r;
      do_reset();
      m = 1; pd = 1'b0; pt = 1'b0;
      for (int c = 0; c < 3000; c++) begin
        @(negedge clk);
        r  = ($urandom_range(0, 63) == 0);
        d  = ($urandom_range(0, 2) != 0);
        s  = ($urandom_range(0, 3) == 0);
        i  = 1'($urandom);
        t  = 1'($urandom);
        dd = 1'($urandom);
        rst = r; display = d; setup_month = s; inc_dec_month = i;
        tick = t; done_day = dd;
        curr_year = 7'($urandom_range(0, 99));
        exp_done = 0;
        if (r) begin
          m = 1; pd = 1'b0; pt = 1'b0;
        end else begin
          if (!d && dd && !pd) begin
            exp_done = (m == 12) ? 1 : 0;
            m = (m % 12) + 1;
          end else if (d && !s && t && !pt) begin
            m = i ? (m % 12) + 1 : ((m + 10) % 12) + 1;
          end
          pd = dd; pt = t;
        end
        @(posedge clk);
        #1;
        chk("rand_month", {26'd0, month}, m);
        chk("rand_done", {31'd0, done_month}, exp_done);
        chk("rand_len", {26'd0, month_len}, model_len(m, int'(curr_year)));
      end
      rst = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/months.md
# months

Month-of-year counter, directly downstream of the day counter in the clock/century datapath. In run mode it advances once per rising edge of `done_day` and emits `done_month` to the year stage on the December-to-January wrap. In display/setup mode it is edited by tick pulses. It also returns the current month length, leap-year aware, for the day stage's wrap target.

## Interface
Parameters: none.

- `clk`  input  1  system clock, rising edge active
- `rst`  input  1  reset, asynchronous, active-high
- `display`  input  1  0 = run (timekeeping), 1 = display/setup mode
- `setup_month`  input  1  active-low edit enable; editing only when `display`=1 and `setup_month`=0
- `inc_dec_month`  input  1  edit direction: 1 = increment, 0 = decrement
- `tick`  input  1  edit strobe from the button/debounce stage
- `done_day`  input  1  day-stage rollover flag; changes on the falling edge of `clk`
- `curr_year`  input  7  current year (0..99); leap when `curr_year[1:0]`==2'b00
- `month`  output  6  current month, 1..12, registered
- `month_len`  output  6  days in current month (28/29/30/31), combinational from `month` and `curr_year`
- `done_month`  output  1  one-cycle registered pulse on the 12→1 wrap in run mode

## Operation
- State registers: `month` [5:0], `done_month`, `done_day_d`, `tick_d`.
- Edge detect:
  - `day_evt = done_day & ~done_day_d`
  - `tick_evt = tick & ~tick_d`
  - Both `_d` registers update every cycle in every mode. A `done_day` level held across a mode change therefore never produces a second event.
- Run mode (`display`=0):
  - `day_evt` with `month` in 1..11: `month` ← `month`+1.
  - `day_evt` with `month`=12: `month` ← 1 and `done_month` ← 1.
  - `tick` and `inc_dec_month` are ignored.
- Edit mode (`display`=1, `setup_month`=0), on `tick_evt`:
  - `inc_dec_month`=1: `month` ← `month`+1; 12 wraps to 1.
  - `inc_dec_month`=0: `month` ← `month`−1; 1 wraps to 12.
  - `done_month` is never asserted in edit mode.
  - `done_day` is ignored.
- Hold mode (`display`=1, `setup_month`=1): `month` holds; `done_month` is 0.
- `done_month` is 0 on every cycle other than the one following a run-mode wrap.
- Recovery: if `month` is 0 or >12 at any posedge, the next value is 1 regardless of mode or events. No `done_month` is generated by recovery.
- `month_len`:
  - 31 for months 1, 3, 5, 7, 8, 10, 12.
  - Month 2: 29 when `curr_year[1:0]`==0, else 28.
  - 30 for 4, 6, 9, 11, and for any out-of-range value.
- Arithmetic is 6-bit unsigned. The wrap checks make overflow or underflow unreachable.

## Timing
- Reset values (asynchronous, immediate): `month`=1, `done_month`=0, `done_day_d`=0, `tick_d`=0. `month_len` therefore reads 31.
- Reset asserted mid-operation wins over every event in that cycle. Deassertion takes effect at the next posedge.
- Latency from `done_day` rise to `month` update:
  - `done_day` rises at negedge N−½.
  - It is sampled at posedge N; `month` updates at posedge N (one edge).
  - `done_month` is high from posedge N to posedge N+1, aligned with `month` becoming 1.
- Latency from `tick` rise to `month` update: one posedge.
- A `tick` held high for several cycles produces exactly one step.
- A run-mode `done_day` held high for several cycles produces exactly one step.
- Mode is sampled at the same posedge as the event. An event coincident with a `display` change follows the new sampled `display` value.
- `month_len` settles combinationally after `month` or `curr_year` changes. It is valid for the day stage before the next posedge.

## Test plan
- Reset then run:
  - Pulse `done_day` 11 times (1 cycle high, ≥1 low) → `month` steps 1..12, `done_month` stays 0.
  - 12th pulse → `month`=1, `done_month`=1 for exactly one cycle.
- `done_day` held high for 5 cycles in run mode with `month`=3 → `month`=4 once, no further change.
- Edit mode (`display`=1, `setup_month`=0):
  - `inc_dec_month`=0 from `month`=1, one tick → 12.
  - `inc_dec_month`=1, one tick → 1.
  - `done_month` stays 0 throughout.
  - `tick` held 4 cycles → single step.
- `month_len` checks:
  - `month`=2, `curr_year`=24 → 29.
  - `curr_year`=23 → 28.
  - `month`=4 → 30.
  - `month`=12 → 31.
- Hold and ignore rules:
  - `display`=1, `setup_month`=1: ticks and `done_day` pulses → `month` unchanged.
  - `display`=0: ticks → `month` unchanged.
- Reset and recovery:
  - Assert `rst` mid-run at `month`=7 with `done_day` high → `month`=1, `done_month`=0 immediately.
  - After release, the still-high `done_day` produces one step to 2.
  - Force `month`=13 → next posedge `month`=1.
